// File: rtl/wb_drain_controller_if.sv
// Bus bundle between the write-back drain controller and its neighbours:
// the cache (eviction and read-miss requests), the write-back replacement
// buffer (head entry and pointer/load strobes) and the physical-memory port.
//
// Modports:
//   master : the drain controller (drives acks, strobes, buffer controls)
//   slave  : the environment (cache, buffer and memory together)
//
// Handshake semantics, in one place:
//   - evict_req is held by the cache until evict_ack; evict_ack is the same
//     signal as rb_load_line, so an acked line is pushed that very cycle.
//   - miss_read is held by the cache until the one-cycle miss_resp pulse;
//     miss_rdata is valid only in that pulse cycle.
//   - pmem_read / pmem_write are level strobes held with a stable address
//     (and write data) until the cycle that memory raises pmem_resp; the
//     strobe drops on the following cycle.
interface wb_drain_controller_if;
  logic         evict_req;
  logic         evict_ack;
  logic         miss_read;
  logic [15:0]  miss_addr;
  logic         miss_resp;
  logic [255:0] miss_rdata;
  logic         rb_full;
  logic         rb_waiting;
  logic [255:0] rb_line;
  logic [10:0]  rb_tag;
  logic         rb_load_word;
  logic         rb_load_line;
  logic         rb_inc_cur_ptr;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    input  evict_req, miss_read, miss_addr, rb_full, rb_waiting, rb_line,
           rb_tag, rb_load_word, pmem_rdata, pmem_resp,
    output evict_ack, miss_resp, miss_rdata, rb_load_line, rb_inc_cur_ptr,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output evict_req, miss_read, miss_addr, rb_full, rb_waiting, rb_line,
           rb_tag, rb_load_word, pmem_rdata, pmem_resp,
    input  evict_ack, miss_resp, miss_rdata, rb_load_line, rb_inc_cur_ptr,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/wb_drain_controller.sv
// Write-back buffer drain sequencer and physical-memory port arbiter.
// Accepts evicted dirty lines into the replacement buffer, drains them to
// memory in FIFO order, and shares the single memory port with cache read
// misses. Reads win by default, but a pending drain is forced after
// MAX_READ_STREAK back-to-back reads, when the buffer is full, or after
// IDLE_DRAIN_DELAY idle cycles.
//
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous, active-high
//   bus         : cache / buffer / memory bundle (master side)
//   dbg_state_o : current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 RETIRE)
module wb_drain_controller #(
  parameter int unsigned MAX_READ_STREAK  = 4,
  parameter int unsigned IDLE_DRAIN_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_drain_controller_if.master   bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    RETIRE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   streak_q, streak_d;
  logic [3:0]   idle_cnt_q, idle_cnt_d;
  logic [10:0]  tag_q, tag_d;

  logic         drain_go;
  logic         miss_resp;
  logic [255:0] miss_rdata;
  logic         inc_cur_ptr;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         load_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      idle_cnt_q <= 4'd0;
      tag_q      <= 11'd0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      idle_cnt_q <= idle_cnt_d;
      tag_q      <= tag_d;
    end
  end

  // A waiting drain preempts reads once any starvation bound is reached.
  assign drain_go = bus.rb_waiting &&
                    (bus.rb_full ||
                     (streak_q == 4'(MAX_READ_STREAK)) ||
                     (idle_cnt_q >= 4'(IDLE_DRAIN_DELAY)));

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    idle_cnt_d   = idle_cnt_q;
    tag_d        = tag_q;
    miss_resp    = 1'b0;
    miss_rdata   = '0;
    inc_cur_ptr  = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    // An outstanding miss always restarts the idle window.
    if (bus.miss_read) idle_cnt_d = 4'd0;

    unique case (state_q)
      IDLE: begin
        if (drain_go) begin
          state_d    = WRITE;
          streak_d   = 4'd0;
          idle_cnt_d = 4'd0;
        end else if (bus.miss_read) begin
          state_d    = READ;
          tag_d      = bus.miss_addr[15:5];
          idle_cnt_d = 4'd0;
          // The streak only measures reads that actually held off a drain.
          streak_d   = bus.rb_waiting ? streak_q + 4'd1 : 4'd0;
        end else if (idle_cnt_q != 4'd15) begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = {tag_q, 5'b0};
        if (bus.pmem_resp) begin
          miss_resp  = 1'b1;
          miss_rdata = bus.pmem_rdata;
          state_d    = IDLE;
        end
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {bus.rb_tag, 5'b0};
        // Live head data, so word writes landing mid-drain reach memory.
        pmem_wdata   = bus.rb_line;
        if (bus.pmem_resp) state_d = RETIRE;
      end
      RETIRE: begin
        // The buffer favours load strobes over retire; wait out word writes.
        if (!bus.rb_load_word) begin
          inc_cur_ptr = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RETIRE blocks new line loads so the pointer bump is never dropped.
  assign load_line = bus.evict_req && !bus.rb_full && (state_q != RETIRE) && !reset;

  assign bus.evict_ack      = load_line;
  assign bus.rb_load_line   = load_line;
  assign bus.rb_inc_cur_ptr = inc_cur_ptr && !reset;
  assign bus.miss_resp      = miss_resp;
  assign bus.miss_rdata     = miss_rdata;
  assign bus.pmem_read      = pmem_read;
  assign bus.pmem_write     = pmem_write;
  assign bus.pmem_address   = pmem_address;
  assign bus.pmem_wdata     = pmem_wdata;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_wb_drain_controller.sv
// Directed bench for wb_drain_controller with a buffer/cache/memory model
// and a scoreboard of expected memory transactions.
module tb_wb_drain_controller;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  wb_drain_controller_if bus ();

  wb_drain_controller #(
    .MAX_READ_STREAK (4),
    .IDLE_DRAIN_DELAY(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Environment models.
  logic [10:0]  buf_q[$];   // tags held in the replacement buffer
  logic [10:0]  ev_q[$];    // evictions the cache still has to hand over
  logic [15:0]  miss_q[$];  // outstanding miss addresses, head is presented
  logic [16:0]  exp_q[$];   // expected memory transactions {is_write, address}
  bit           force_full;
  int           mem_lat;
  int           mem_cnt;
  int           inc_count;
  logic [255:0] rdata_pat;

  // Per-cycle samples taken mid-cycle.
  logic [1:0]   s_state;
  logic         s_read, s_write, s_resp, s_ack, s_inc, s_mresp;
  logic [15:0]  s_addr;
  logic [255:0] s_mrdata, s_wdata;

  function automatic logic [255:0] line_of(input logic [10:0] t);
    return {16{5'b0, t}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.evict_req  = (ev_q.size() != 0);
    bus.miss_read  = (miss_q.size() != 0);
    bus.miss_addr  = (miss_q.size() != 0) ? miss_q[0] : 16'd0;
    bus.rb_waiting = (buf_q.size() != 0);
    bus.rb_full    = force_full || (buf_q.size() == 15);
    bus.rb_tag     = (buf_q.size() != 0) ? buf_q[0] : 11'd0;
    bus.rb_line    = (buf_q.size() != 0) ? line_of(buf_q[0]) : 256'd0;
    bus.pmem_rdata = rdata_pat;
  endtask

  // One clock cycle: memory answers and outputs are sampled at the falling
  // edge, the environment models advance just after the rising edge.
  task automatic tick();
    logic [16:0] obs, e;
    @(negedge clk);
    bus.pmem_resp = (bus.pmem_read || bus.pmem_write) && (mem_cnt >= mem_lat) && !reset;
    #1;
    s_state  = dbg_state;
    s_read   = bus.pmem_read;
    s_write  = bus.pmem_write;
    s_resp   = bus.pmem_resp;
    s_ack    = bus.evict_ack;
    s_inc    = bus.rb_inc_cur_ptr;
    s_mresp  = bus.miss_resp;
    s_addr   = bus.pmem_address;
    s_mrdata = bus.miss_rdata;
    s_wdata  = bus.pmem_wdata;
    check("miss_resp_only_on_read_resp", 256'(s_mresp), 256'(s_resp && s_read));
    if (s_resp && (s_read || s_write)) begin
      obs = {s_write, s_addr};
      check("sb_has_expected", 256'(exp_q.size() != 0), 256'(1'b1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("txn", 256'(obs), 256'(e));
        if (s_write) check("wdata", s_wdata, line_of(e[15:5]));
        else         check("miss_rdata", s_mrdata, rdata_pat);
      end
    end
    @(posedge clk);
    #1;
    if (!(s_read || s_write) || s_resp) mem_cnt = 0;
    else                                mem_cnt++;
    if (s_ack && ev_q.size() != 0) buf_q.push_back(ev_q.pop_front());
    if (s_inc) begin
      inc_count++;
      if (buf_q.size() != 0) void'(buf_q.pop_front());
    end
    if (s_mresp && miss_q.size() != 0) void'(miss_q.pop_front());
    bus.pmem_resp = 1'b0;
    drive_inputs();
  endtask

  task automatic wait_write(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!s_write && n < budget);
    check({tag, "_write_seen"}, 256'(s_write), 256'(1'b1));
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && (ev_q.size() == 0) && (miss_q.size() == 0) &&
             (buf_q.size() == 0) && (s_state == 2'd0) && (bus.rb_load_word == 1'b0);
    end
    check({tag, "_drained"}, 256'(done), 256'(1'b1));
  endtask

  initial begin
    logic [10:0] t;
    logic [15:0] a;
    int          inc_base;

    // ---------------- clock/reset ----------------
    reset            = 1'b1;
    force_full       = 1'b0;
    mem_lat          = 1;
    mem_cnt          = 0;
    inc_count        = 0;
    rdata_pat        = {8{32'h1234_5678}};
    bus.rb_load_word = 1'b0;
    bus.pmem_resp    = 1'b0;
    drive_inputs();
    repeat (3) tick();
    check("rst_state",     256'(s_state), 256'(2'd0));
    check("rst_pmem_read", 256'(s_read),  256'(1'b0));
    check("rst_pmem_write",256'(s_write), 256'(1'b0));
    check("rst_pmem_addr", 256'(s_addr),  256'(16'd0));
    check("rst_miss_rdata",s_mrdata,      256'd0);
    check("rst_inc",       256'(s_inc),   256'(1'b0));
    reset = 1'b0;

    // ---------------- single eviction, idle drain ----------------
    t = 11'h123;
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    inc_base = inc_count;
    tick();
    check("t1_ack_same_cycle", 256'(s_ack),   256'(1'b1));
    check("t1_c0_no_write",    256'(s_write), 256'(1'b0));
    tick();
    check("t1_c1_no_write",    256'(s_write), 256'(1'b0));
    tick();
    check("t1_c2_no_write",    256'(s_write), 256'(1'b0));
    tick();
    check("t1_c3_write",       256'(s_write), 256'(1'b1));
    check("t1_c3_addr",        256'(s_addr),  256'(16'h2460));
    wait_drained("t1", 30);
    check("t1_one_retire", 256'(inc_count - inc_base), 256'(1));

    // ---------------- read streak forces a drain ----------------
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    wait_write("t2_b", 10);
    // C and D land while the buffer is draining B, misses queue up behind.
    for (int i = 0; i < 2; i++) ev_q.push_back(11'($urandom_range(0, 2047)));
    for (int i = 0; i < 6; i++) miss_q.push_back(16'($urandom_range(0, 65535)));
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, miss_q[i][15:5], 5'b0});
    exp_q.push_back({1'b1, ev_q[0], 5'b0});
    for (int i = 4; i < 6; i++) exp_q.push_back({1'b0, miss_q[i][15:5], 5'b0});
    exp_q.push_back({1'b1, ev_q[1], 5'b0});
    drive_inputs();
    wait_drained("t2", 200);

    // ---------------- full buffer beats a read, stalls evictions ----------------
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    tick();
    check("t3_e_ack", 256'(s_ack), 256'(1'b1));
    force_full = 1'b1;
    a = 16'($urandom_range(0, 65535));
    miss_q.push_back(a);
    exp_q.push_back({1'b0, a[15:5], 5'b0});
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    begin
      int n = 0;
      do begin
        tick();
        n++;
        check("t3_ack_stalled_full", 256'(s_ack), 256'(1'b0));
      end while (!s_inc && n < 20);
      check("t3_retire_seen", 256'(s_inc), 256'(1'b1));
    end
    force_full = 1'b0;
    drive_inputs();
    tick();
    check("t3_ack_after_full", 256'(s_ack), 256'(1'b1));
    wait_drained("t3", 60);

    // ---------------- word writes during retire ----------------
    mem_lat = 1;
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    wait_write("t4", 10);
    tick();
    check("t4_write_resp", 256'(s_resp && s_write), 256'(1'b1));
    bus.rb_load_word = 1'b1;
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    inc_base = inc_count;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_hold_state", 256'(s_state), 256'(2'd3));
      check("t4_hold_no_inc", 256'(s_inc),  256'(1'b0));
      check("t4_hold_no_ack", 256'(s_ack),  256'(1'b0));
    end
    bus.rb_load_word = 1'b0;
    tick();
    check("t4_inc_pulse",  256'(s_inc), 256'(1'b1));
    check("t4_inc_no_ack", 256'(s_ack), 256'(1'b0));
    tick();
    check("t4_ack_after",  256'(s_ack),   256'(1'b1));
    check("t4_back_idle",  256'(s_state), 256'(2'd0));
    wait_drained("t4", 40);
    check("t4_retires", 256'(inc_count - inc_base), 256'(2));

    // ---------------- read address alignment and data ----------------
    rdata_pat = {32{8'hA5}};
    miss_q.push_back(16'h1237);
    exp_q.push_back({1'b0, 16'h1220});
    drive_inputs();
    tick();
    check("t5_grant_no_strobe", 256'(s_read), 256'(1'b0));
    tick();
    check("t5_read",      256'(s_read), 256'(1'b1));
    check("t5_addr",      256'(s_addr), 256'(16'h1220));
    tick();
    check("t5_miss_resp", 256'(s_mresp), 256'(1'b1));
    check("t5_rdata",     s_mrdata,      {32{8'hA5}});
    wait_drained("t5", 20);

    // Minimum-length read: memory answers in the first strobe cycle.
    mem_lat = 0;
    rdata_pat = {8{32'($urandom)}};
    a = 16'($urandom_range(0, 65535));
    miss_q.push_back(a);
    exp_q.push_back({1'b0, a[15:5], 5'b0});
    drive_inputs();
    tick();
    tick();
    check("t5b_read_resp", 256'(s_read && s_resp && s_mresp), 256'(1'b1));
    tick();
    check("t5b_strobe_drop", 256'(s_read), 256'(1'b0));
    wait_drained("t5b", 20);

    // ---------------- reset mid-WRITE ----------------
    mem_lat = 6;
    t = 11'($urandom_range(0, 2047));
    ev_q.push_back(t);
    exp_q.push_back({1'b1, t, 5'b0});
    drive_inputs();
    inc_base = inc_count;
    wait_write("t6", 10);
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_no_inc", 256'(s_inc), 256'(1'b0));
    reset = 1'b0;
    tick();
    check("t6_idle_after_rst", 256'(s_state), 256'(2'd0));
    check("t6_write_dropped",  256'(s_write), 256'(1'b0));
    check("t6_no_inc",         256'(s_inc),   256'(1'b0));
    mem_lat = 1;
    wait_drained("t6", 40);
    check("t6_single_retire", 256'(inc_count - inc_base), 256'(1));
    check("final_sb_empty", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_drain_controller.md
# wb_drain_controller

Sequencer and memory-port arbiter for the write-back replacement buffer in the L2/physical-memory path. It accepts evicted dirty lines from the cache into the buffer and drains buffered lines to physical memory in FIFO order. It shares the single physical-memory port between cache read misses and buffer drains, using a starvation-bounded priority scheme. It also keeps the buffer's pointer and load strobes from colliding in the same cycle.

## Interface
- MAX_READ_STREAK, 4: consecutive reads granted while a drain is pending before a drain is forced (1..15).
- IDLE_DRAIN_DELAY, 2: idle cycles with no miss before an opportunistic drain starts (0..15).
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- evict_req  in  1  Cache presents a dirty line to be buffered.
- evict_ack  out  1  Eviction accepted this cycle (equals rb_load_line).
- miss_read  in  1  Cache read miss (already missed in the buffer); held until miss_resp.
- miss_addr  in  16  Miss byte address.
- miss_resp  out  1  One-cycle pulse: miss_rdata valid.
- miss_rdata  out  256  Line returned for the miss.
- rb_full  in  1  Buffer full (15 entries).
- rb_waiting  in  1  Entry at the buffer's cur_ptr is pending a drain.
- rb_line  in  256  Line data at cur_ptr.
- rb_tag  in  11  Tag (address [15:5]) at cur_ptr.
- rb_load_word  in  1  Cache is writing a word into the buffer this cycle.
- rb_load_line  out  1  Push the evicted line into the buffer.
- rb_inc_cur_ptr  out  1  Retire the entry at cur_ptr.
- pmem_read, pmem_write  out  1  Memory strobes, held until pmem_resp.
- pmem_address  out  16  Line-aligned address; bits [4:0] are always 0.
- pmem_wdata  out  256  Write data.
- pmem_rdata  in  256  Read data.
- pmem_resp  in  1  Memory transaction complete.

## Operation
- FSM states: IDLE, READ, WRITE, RETIRE. Reset → IDLE.
- Grant decision, evaluated in IDLE:
  - First priority: rb_waiting && (rb_full || streak == MAX_READ_STREAK || idle_cnt >= IDLE_DRAIN_DELAY) → WRITE.
  - Else if miss_read → READ. miss_addr[15:5] is latched; streak increments when rb_waiting is set, otherwise clears.
  - Else stay in IDLE; idle_cnt increments, saturating at 15.
- Counter clearing:
  - idle_cnt clears on any grant and whenever miss_read is high.
  - streak clears on entry to WRITE.
- READ:
  - pmem_read = 1, pmem_address = {latched tag, 5'b0}.
  - On pmem_resp: miss_resp = 1 and miss_rdata = pmem_rdata in the same cycle, then → IDLE.
- WRITE:
  - pmem_write = 1, pmem_address = {rb_tag, 5'b0}.
  - pmem_wdata = rb_line, combinational and live, so word writes into the head entry during the drain reach memory.
  - On pmem_resp → RETIRE.
- RETIRE:
  - rb_inc_cur_ptr = 1 only when rb_load_word = 0, then → IDLE.
  - Otherwise stay in RETIRE.
- Eviction path:
  - rb_load_line = evict_ack = evict_req && !rb_full && state != RETIRE && !reset.
  - The cache holds evict_req until acknowledged.
- Invariant: rb_load_line, rb_load_word and rb_inc_cur_ptr are never high together in a way that drops an update. The buffer prioritises load_line over retire, so RETIRE blocks evictions and waits out word writes.

## Timing
- Reset values:
  - State IDLE; streak and idle_cnt 0.
  - All outputs 0, including miss_rdata and pmem_address.
- Grant latency: a request seen in IDLE at edge N puts the strobe high from cycle N+1.
- Minimum transaction lengths:
  - Read: 2 cycles (grant + resp).
  - Drain: 3 cycles (grant, resp, retire).
- Strobes are level signals, held constant until pmem_resp and dropped the cycle after resp.
- miss_read deasserted mid-READ is ignored; the transaction completes and miss_resp still pulses.
- Reset in any state returns to IDLE next edge. A memory transaction in flight is abandoned and no retire is issued.
- Buffer wrap-around is handled by the buffer; the controller relies only on rb_waiting and rb_full.

## Test plan
- Single eviction, no misses, IDLE_DRAIN_DELAY=2: evict_req 1 cycle into an empty buffer → evict_ack same cycle; WRITE starts 3 cycles later at {rb_tag,5'b0}; one rb_inc_cur_ptr pulse after pmem_resp.
- Buffer holds 2 entries and miss_read is held continuously, MAX_READ_STREAK=4 → 4 READs, then 1 forced WRITE with streak reset to 0, then READs resume.
- rb_full=1 with miss_read=1 → WRITE granted before READ; evict_req is stalled (evict_ack=0) until rb_full drops.
- pmem_resp in WRITE while evict_req=1 and rb_load_word=1 for 2 cycles → RETIRE holds rb_inc_cur_ptr low for 2 cycles with evict_ack=0; the pulse comes on the third cycle, and evict_ack rises the cycle after.
- miss_addr=16'h1237 → pmem_address=16'h1220; pmem_rdata=256'hA5..A5 appears on miss_rdata with miss_resp in the pmem_resp cycle.
- Reset asserted mid-WRITE → next cycle state IDLE, pmem_write=0, no rb_inc_cur_ptr pulse.
